// File: rtl/sa_wst_ctrl.sv
// Job sequencer for a weight-stationary systolic array: load weights, latch, then stream skewed fmap vectors.
// Latency: o_busy/o_w_req assert the cycle after i_start; ROWS+1+(N+ROWS+COLS-1)+1 busy cycles (ROWS+2 when N=0).
// Backpressure: none; i_start is ignored while busy (no queuing), i_abort returns to IDLE from any state.
module sa_wst_ctrl #(
   parameter int ROWS = 4,
   parameter int COLS = 4,
   parameter int K_BW = 8
) (
   input  logic            clk,
   input  logic            rst_n,
   input  logic            i_start,
   input  logic [K_BW-1:0] i_num_vec,
   input  logic            i_abort,
   output logic            o_busy,
   output logic            o_done,
   output logic            o_w_req,
   output logic            o_str_en,
   output logic            o_mul_en,
   output logic [ROWS-1:0] o_f_req,
   output logic [COLS-1:0] o_pe_en,
   output logic [COLS-1:0] o_col_valid
);

   // k is one bit wider than N so the longest compute phase never wraps
   localparam int KW = K_BW + 1;

   typedef enum logic [2:0] {
      S_IDLE    = 3'd0,
      S_LOAD_W  = 3'd1,
      S_LATCH   = 3'd2,
      S_COMPUTE = 3'd3,
      S_DONE    = 3'd4
   } state_t;

   state_t          state_q, state_d;
   logic [KW-1:0]   k_q, k_d;
   logic [K_BW-1:0] n_q, n_d;

   logic [KW-1:0]   n_ext;
   logic [KW-1:0]   comp_last;

   assign n_ext     = {1'b0, n_q};
   // Last compute cycle index: L-1 = N+ROWS+COLS-2
   assign comp_last = n_ext + KW'(ROWS + COLS - 2);

   // State, counter and latched vector count registers
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= S_IDLE;
         k_q     <= '0;
         n_q     <= '0;
      end else begin
         state_q <= state_d;
         k_q     <= k_d;
         n_q     <= n_d;
      end
   end

   // Next-state logic plus output decode; outputs depend only on the flops
   always_comb begin
      state_d     = state_q;
      k_d         = k_q + KW'(1);
      n_d         = n_q;
      o_busy      = 1'b0;
      o_done      = 1'b0;
      o_w_req     = 1'b0;
      o_str_en    = 1'b0;
      o_mul_en    = 1'b0;
      o_f_req     = '0;
      o_pe_en     = '0;
      o_col_valid = '0;

      case (state_q)
         S_IDLE: begin
            k_d = '0;
            if (i_start) begin
               n_d     = i_num_vec;
               state_d = S_LOAD_W;
            end
         end
         S_LOAD_W: begin
            o_busy  = 1'b1;
            o_w_req = 1'b1;
            o_pe_en = '1;
            if (k_q == KW'(ROWS - 1)) begin
               state_d = S_LATCH;
               k_d     = '0;
            end
         end
         S_LATCH: begin
            o_busy   = 1'b1;
            o_str_en = 1'b1;
            o_pe_en  = '1;
            k_d      = '0;
            // A zero-length job only loads weights
            state_d  = (n_q != '0) ? S_COMPUTE : S_DONE;
         end
         S_COMPUTE: begin
            o_busy   = 1'b1;
            o_mul_en = 1'b1;
            // Row r injects its N vectors skewed by r cycles
            for (int r = 0; r < ROWS; r++) begin
               o_f_req[r] = (k_q >= KW'(r)) && (k_q < KW'(r) + n_ext);
            end
            // Column c results emerge after ROWS+c cycles; the column is
            // clock-gated once its last result has left
            for (int c = 0; c < COLS; c++) begin
               o_col_valid[c] = (k_q >= KW'(c + ROWS)) && (k_q < KW'(c + ROWS) + n_ext);
               o_pe_en[c]     = (k_q < KW'(c + ROWS) + n_ext);
            end
            if (k_q == comp_last) begin
               state_d = S_DONE;
               k_d     = '0;
            end
         end
         S_DONE: begin
            o_busy  = 1'b1;
            o_done  = 1'b1;
            state_d = S_IDLE;
            k_d     = '0;
         end
         default: begin
            state_d = S_IDLE;
            k_d     = '0;
         end
      endcase

      // Abort overrides every transition and drops the pending job
      if (i_abort) begin
         state_d = S_IDLE;
         k_d     = '0;
         n_d     = '0;
      end
   end

endmodule

// File: tb/tb_sa_wst_ctrl.sv
// Testbench for sa_wst_ctrl: table-driven job scenarios, hand-written corner sequences, random jobs.
// Latency: checks every cycle of each job against a time-offset reference model.
// Backpressure: n/a.
module tb_sa_wst_ctrl;
   localparam int R  = 4;
   localparam int C  = 4;
   localparam int KB = 8;

   logic          clk;
   logic          rst_n;
   logic          i_start;
   logic [KB-1:0] i_num_vec;
   logic          i_abort;
   logic          o_busy, o_done, o_w_req, o_str_en, o_mul_en;
   logic [R-1:0]  o_f_req;
   logic [C-1:0]  o_pe_en;
   logic [C-1:0]  o_col_valid;

   int pass_cnt = 0;
   int chk_cnt  = 0;

   sa_wst_ctrl #(.ROWS(R), .COLS(C), .K_BW(KB)) dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .i_start     (i_start),
      .i_num_vec   (i_num_vec),
      .i_abort     (i_abort),
      .o_busy      (o_busy),
      .o_done      (o_done),
      .o_w_req     (o_w_req),
      .o_str_en    (o_str_en),
      .o_mul_en    (o_mul_en),
      .o_f_req     (o_f_req),
      .o_pe_en     (o_pe_en),
      .o_col_valid (o_col_valid)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Packed view: {busy, done, w_req, str, mul, f_req[3:0], pe_en[3:0], col_valid[3:0]}
   function automatic logic [16:0] act_vec();
      return {o_busy, o_done, o_w_req, o_str_en, o_mul_en, o_f_req, o_pe_en, o_col_valid};
   endfunction

   // Expected outputs t cycles after the start edge, from the job's time line
   function automatic logic [16:0] model(int n, int t);
      logic [3:0] fr, pe, cv;
      logic busy, done, wr, st, mu;
      int len, total, k;
      fr = '0; pe = '0; cv = '0;
      busy = 0; done = 0; wr = 0; st = 0; mu = 0;
      len   = n + R + C - 1;
      total = (n == 0) ? R + 2 : R + 1 + len + 1;
      if (t >= 0 && t < total) begin
         busy = 1;
         if (t < R) begin
            wr = 1; pe = '1;
         end else if (t == R) begin
            st = 1; pe = '1;
         end else if (t == total - 1) begin
            done = 1;
         end else begin
            k  = t - R - 1;
            mu = 1;
            for (int r = 0; r < R; r++) fr[r] = (k >= r) && (k < r + n);
            for (int c = 0; c < C; c++) begin
               cv[c] = (k >= c + R) && (k < c + R + n);
               pe[c] = (k < c + R + n);
            end
         end
      end
      return {busy, done, wr, st, mu, fr, pe, cv};
   endfunction

   function automatic int busy_len(int n);
      return (n == 0) ? R + 2 : R + 1 + (n + R + C - 1) + 1;
   endfunction

   task automatic chk(input string name, input longint act, input longint exp);
      chk_cnt++;
      if (act == exp) pass_cnt++;
      else $display("FAIL %s: actual=0x%0h required=0x%0h (t=%0t)", name, act, exp, $time);
   endtask

   // Run one job from i_start until two cycles past its end, checking every cycle
   task automatic run_job(input int n, input int abort_t, input bit noise,
                          output int busy_c, output int done_c, output int wr_c,
                          output int st_c, output int mul_c, output int fr2_c,
                          output int cv3_c);
      int total;
      bit aborted;
      logic [16:0] a, e;
      total = busy_len(n);
      aborted = 0;
      busy_c = 0; done_c = 0; wr_c = 0; st_c = 0; mul_c = 0; fr2_c = 0; cv3_c = 0;
      i_num_vec = KB'(n);
      i_start   = 1'b1;
      @(posedge clk); #1;
      i_start = 1'b0;
      for (int t = 0; t <= total + 1; t++) begin
         e = aborted ? 17'd0 : model(n, t);
         a = act_vec();
         chk($sformatf("cycle n=%0d t=%0d", n, t), a, e);
         busy_c += a[16]; done_c += a[15]; wr_c += a[14]; st_c += a[13];
         mul_c  += a[12]; fr2_c  += a[10]; cv3_c += a[3];
         i_abort = (t == abort_t);
         if (i_abort) aborted = 1;
         // Spurious starts while busy must be ignored (never in IDLE)
         i_start   = noise && !aborted && (t < total) && ($urandom_range(0, 1) == 1);
         i_num_vec = KB'($urandom);
         @(posedge clk); #1;
         i_abort = 1'b0;
         i_start = 1'b0;
      end
   endtask

   typedef struct {
      int n; int abort_t; bit noise;
      int busy; int done; int wr; int st; int mul; int fr2; int cv3;
   } vec_t;

   vec_t tbl[6];

   initial begin
      int b, d, w, s, m, f, v, n, ab, wait_cnt;
      bit seen;

      tbl[0] = '{n:3,   abort_t:-1, noise:0, busy:16,  done:1, wr:4, st:1, mul:10,  fr2:3,   cv3:3};
      tbl[1] = '{n:0,   abort_t:-1, noise:0, busy:6,   done:1, wr:4, st:1, mul:0,   fr2:0,   cv3:0};
      tbl[2] = '{n:3,   abort_t:-1, noise:1, busy:16,  done:1, wr:4, st:1, mul:10,  fr2:3,   cv3:3};
      tbl[3] = '{n:3,   abort_t:10, noise:0, busy:11,  done:0, wr:4, st:1, mul:6,   fr2:3,   cv3:0};
      tbl[4] = '{n:255, abort_t:-1, noise:0, busy:268, done:1, wr:4, st:1, mul:262, fr2:255, cv3:255};
      tbl[5] = '{n:1,   abort_t:-1, noise:1, busy:14,  done:1, wr:4, st:1, mul:8,   fr2:1,   cv3:1};

      rst_n = 1'b0; i_start = 1'b0; i_abort = 1'b0; i_num_vec = '0;
      repeat (2) @(posedge clk);
      #1 chk("reset outputs", act_vec(), 0);
      rst_n = 1'b1;
      @(posedge clk); #1 chk("post-reset idle", act_vec(), 0);

      // Table-driven job scenarios
      for (int i = 0; i < 6; i++) begin
         run_job(tbl[i].n, tbl[i].abort_t, tbl[i].noise, b, d, w, s, m, f, v);
         chk($sformatf("tbl%0d busy cycles", i), b, tbl[i].busy);
         chk($sformatf("tbl%0d done pulses", i), d, tbl[i].done);
         chk($sformatf("tbl%0d w_req cycles", i), w, tbl[i].wr);
         chk($sformatf("tbl%0d str cycles", i), s, tbl[i].st);
         chk($sformatf("tbl%0d mul cycles", i), m, tbl[i].mul);
         chk($sformatf("tbl%0d f_req2 cycles", i), f, tbl[i].fr2);
         chk($sformatf("tbl%0d col_valid3 cycles", i), v, tbl[i].cv3);
      end

      // Abort and start together in IDLE: abort wins
      i_start = 1'b1; i_abort = 1'b1; i_num_vec = 8'd5;
      @(posedge clk); #1;
      i_start = 1'b0; i_abort = 1'b0;
      chk("abort+start idle", act_vec(), 0);
      @(posedge clk); #1 chk("abort+start idle 2", act_vec(), 0);

      // Back-to-back: start in the first IDLE cycle after DONE
      i_num_vec = 8'd2; i_start = 1'b1;
      @(posedge clk); #1 i_start = 1'b0;
      seen = 0; wait_cnt = 0;
      while (!seen && wait_cnt < 50) begin
         if (o_done) seen = 1;
         else begin
            @(posedge clk); #1;
            wait_cnt++;
         end
      end
      chk("b2b done seen", seen, 1);
      @(posedge clk); #1 chk("b2b first idle busy", o_busy, 0);
      i_num_vec = 8'd1; i_start = 1'b1;
      @(posedge clk); #1 i_start = 1'b0;
      chk("b2b relaunch busy/w_req", {o_busy, o_w_req}, 2'b11);
      repeat (20) @(posedge clk);
      #1 chk("b2b drained", o_busy, 0);

      // Reset pulse during LOAD_W: outputs drop immediately, stay idle after release
      i_num_vec = 8'd3; i_start = 1'b1;
      @(posedge clk); #1 i_start = 1'b0;
      @(posedge clk); #1 chk("pre-reset load_w", {o_busy, o_w_req}, 2'b11);
      #2 rst_n = 1'b0;
      #1 chk("async reset drop", act_vec(), 0);
      @(posedge clk); #1 chk("in reset", act_vec(), 0);
      rst_n = 1'b1;
      for (int i = 0; i < 3; i++) begin
         @(posedge clk); #1 chk($sformatf("idle after reset %0d", i), act_vec(), 0);
      end

      // Randomized jobs with spurious starts and occasional aborts
      for (int j = 0; j < 20; j++) begin
         n  = ($urandom_range(0, 3) == 0) ? 0 : $urandom_range(1, 40);
         ab = ($urandom_range(0, 3) == 0) ? $urandom_range(0, busy_len(n) - 1) : -1;
         run_job(n, ab, $urandom_range(0, 1), b, d, w, s, m, f, v);
         chk($sformatf("rnd%0d done pulses", j), d, (ab < 0) ? 1 : (ab == busy_len(n) - 1 ? 1 : 0));
      end

      $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
      $finish;
   end

endmodule
